// File: rtl/axi_ad9963_rx_pack_fifo.sv
// axi_ad9963_rx_pack_fifo: first-word-fall-through FIFO holding packed DMA words.
// A write into a full FIFO is accepted only when a pop frees the head slot on the same edge.
module axi_ad9963_rx_pack_fifo #(
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 2 ** ADDR_WIDTH,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full
);
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  wr_ok, rd_ok;

    assign empty   = count_q == '0;
    assign full    = count_q == FULL_CNT;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        rd_ok    = rd_en && !empty;
        wr_ok    = wr_en && (!full || rd_ok);
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(wr_ok);
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(rd_ok);
        count_d  = count_q + (ADDR_WIDTH+1)'(wr_ok) - (ADDR_WIDTH+1)'(rd_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/axi_ad9963_rx_pack.sv
// axi_ad9963_rx_pack: packs AD9963 I/Q samples into 64-bit DMA words by channel-enable mode,
// queues them in a FWFT FIFO and pulses adc_dovf when a completed word finds the FIFO full.
module axi_ad9963_rx_pack #(
    parameter int FIFO_ADDR_WIDTH = 2
) (
    input  logic        adc_clk,
    input  logic        adc_rst,
    input  logic        adc_enable_i,
    input  logic        adc_valid_i,
    input  logic [15:0] adc_data_i,
    input  logic        adc_enable_q,
    input  logic        adc_valid_q,
    input  logic [15:0] adc_data_q,
    input  logic        dma_xfer_req,
    input  logic        dma_ready,
    output logic        dma_valid,
    output logic [63:0] dma_data,
    output logic        adc_dovf
);
    localparam logic [1:0] MODE_IQ = 2'b11;
    localparam logic [1:0] MODE_I  = 2'b01;
    localparam logic [1:0] MODE_Q  = 2'b10;
    localparam int         DEPTH   = 2 ** FIFO_ADDR_WIDTH;

    logic [1:0]  mode_q, mode_in, beat_q, beat_d, last_beat;
    logic [63:0] asm_q, asm_d;
    logic        done_q, done_d, dovf_q, dovf_d;
    logic        flush, strobe, take, complete, pop, fifo_empty, fifo_full;
    logic [15:0] smp;

    assign dma_valid = !fifo_empty;
    assign adc_dovf  = dovf_q;

    always_comb begin
        mode_in   = {adc_enable_q, adc_enable_i};
        flush     = (mode_q != mode_in) || !dma_xfer_req;
        strobe    = adc_enable_i ? adc_valid_i : adc_valid_q;
        take      = !flush && strobe && (mode_q inside {MODE_IQ, MODE_I, MODE_Q});
        last_beat = (mode_q == MODE_IQ) ? 2'd1 : 2'd3;
        complete  = take && (beat_q == last_beat);
        smp       = (mode_q == MODE_Q) ? adc_data_q : adc_data_i;
        asm_d     = flush ? '0 : asm_q;
        if (take && mode_q == MODE_IQ) asm_d[{beat_q[0], 5'd0} +: 32] = {adc_data_q, adc_data_i};
        else if (take) asm_d[{beat_q, 4'd0} +: 16] = smp;
        beat_d    = (flush || complete) ? 2'd0 : take ? beat_q + 2'd1 : beat_q;
        done_d    = complete;
        pop       = !fifo_empty && dma_ready;
        // A pop on the write edge frees the head slot, so a full FIFO still takes the word.
        dovf_d    = done_q && fifo_full && !pop;
    end

    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            mode_q <= 2'b00;
            beat_q <= 2'd0;
            asm_q  <= '0;
            done_q <= 1'b0;
            dovf_q <= 1'b0;
        end else begin
            mode_q <= mode_in;
            beat_q <= beat_d;
            asm_q  <= asm_d;
            done_q <= done_d;
            dovf_q <= dovf_d;
        end
    end

    axi_ad9963_rx_pack_fifo #(
        .ADDR_WIDTH(FIFO_ADDR_WIDTH),
        .DEPTH     (DEPTH),
        .DATA_WIDTH(64)
    ) u_fifo (
        .clk    (adc_clk),
        .rst    (adc_rst),
        .wr_en  (done_q),
        .wr_data(asm_q),
        .rd_en  (pop),
        .rd_data(dma_data),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );
endmodule
